// File: rtl/router_input_buffer.sv
// router_input_buffer: per-port input FIFO for the NoC router.
// Valid/ready on both sides, first-word fall-through head, DEPTH entries
// (any DEPTH >= 2). Handshake outputs decode only registered state and rst.
module router_input_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [DATA_WIDTH-1:0]      in_data,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [DATA_WIDTH-1:0]      out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic                  push, pop;

   // rst gates in_ready directly so it drops the moment reset asserts
   assign in_ready  = !rst && (count < DEPTH_C);
   assign out_valid = (count != '0);
   assign out_data  = mem[rd_ptr];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // storage is write-only on push; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   // pointers wrap by explicit compare so non-power-of-2 depths work
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
   end

   // occupancy: simultaneous push and pop cancel out
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_count_range: assert property (@(posedge clk) disable iff (rst)
      count <= DEPTH_C);
   a_ptr_count: assert property (@(posedge clk) disable iff (rst)
      ((int'(wr_ptr) - int'(rd_ptr) + DEPTH) % DEPTH) == (int'(count) % DEPTH));
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: vector table, hand-written reset / bypass /
// wrap sequences, and a long random run against a queue reference model.
module tb_router_input_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // DEPTH=4 instance
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid;
   logic [31:0] out_data;
   logic [2:0]  count;

   // DEPTH=3 instance for the wrap test
   logic        in_valid3 = 1'b0, out_ready3 = 1'b0;
   logic [31:0] in_data3 = '0;
   logic        in_ready3, out_valid3;
   logic [31:0] out_data3;
   logic [1:0]  count3;

   int checks = 0;
   int errors = 0;

   router_input_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .count(count));

   router_input_buffer #(.DATA_WIDTH(32), .DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3),
      .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
      .out_ready(out_ready3), .count(count3));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // one clock: inputs already driven, sample after the posedge on the negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic        r;
      logic        ov;
      logic [31:0] od;
      logic        ir;
      logic [2:0]  cnt;
   } vec_t;

   vec_t vt [20];
   logic [31:0] q [$];
   logic [31:0] got [$];
   logic        push_m, pop_m;
   int          nxt;

   initial begin
      // fill, full hold, drain, empty, simultaneous push/pop, full with pop
      vt[0]  = '{1, 32'hA0, 0, 1, 32'hA0, 1, 3'd1};
      vt[1]  = '{1, 32'hA1, 0, 1, 32'hA0, 1, 3'd2};
      vt[2]  = '{1, 32'hA2, 0, 1, 32'hA0, 1, 3'd3};
      vt[3]  = '{1, 32'hA3, 0, 1, 32'hA0, 0, 3'd4};
      vt[4]  = '{1, 32'hA4, 0, 1, 32'hA0, 0, 3'd4};
      vt[5]  = '{0, 32'h0,  1, 1, 32'hA1, 1, 3'd3};
      vt[6]  = '{0, 32'h0,  1, 1, 32'hA2, 1, 3'd2};
      vt[7]  = '{0, 32'h0,  1, 1, 32'hA3, 1, 3'd1};
      vt[8]  = '{0, 32'h0,  1, 0, 32'h0,  1, 3'd0};
      vt[9]  = '{0, 32'h0,  1, 0, 32'h0,  1, 3'd0};
      vt[10] = '{1, 32'hB0, 0, 1, 32'hB0, 1, 3'd1};
      vt[11] = '{1, 32'hB1, 0, 1, 32'hB0, 1, 3'd2};
      vt[12] = '{1, 32'hB5, 1, 1, 32'hB1, 1, 3'd2};
      vt[13] = '{1, 32'hB6, 0, 1, 32'hB1, 1, 3'd3};
      vt[14] = '{1, 32'hB7, 0, 1, 32'hB1, 0, 3'd4};
      vt[15] = '{1, 32'hB8, 1, 1, 32'hB5, 1, 3'd3};
      vt[16] = '{1, 32'hB8, 1, 1, 32'hB6, 1, 3'd3};
      vt[17] = '{0, 32'h0,  1, 1, 32'hB7, 1, 3'd2};
      vt[18] = '{0, 32'h0,  1, 1, 32'hB8, 1, 3'd1};
      vt[19] = '{0, 32'h0,  1, 0, 32'h0,  1, 3'd0};

      // reset state
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_count",     {29'd0, count},     32'd0);
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // table-driven vectors
      for (int i = 0; i < 20; i++) begin
         in_valid = vt[i].v; in_data = vt[i].d; out_ready = vt[i].r;
         step();
         chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vt[i].ov});
         chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vt[i].ir});
         chk($sformatf("vec%0d_count", i),     {29'd0, count},     {29'd0, vt[i].cnt});
         if (vt[i].ov) chk($sformatf("vec%0d_out_data", i), out_data, vt[i].od);
      end

      // no bypass: push into empty is not visible before the edge
      in_valid = 1'b1; in_data = 32'hC0; out_ready = 1'b1;
      #1;
      chk("nobypass_out_valid", {31'd0, out_valid}, 32'd0);
      step();
      in_valid = 1'b0;
      chk("push_empty_out_valid", {31'd0, out_valid}, 32'd1);
      chk("push_empty_out_data",  out_data, 32'hC0);
      step();   // C0 popped
      chk("pop_after_1_count", {29'd0, count}, 32'd0);

      // reset mid-stream with three flits buffered
      out_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'hD0 + i;
         step();
      end
      chk("pre_rst_count", {29'd0, count}, 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("async_rst_count",     {29'd0, count},     32'd0);
      step();   // in_valid still high during reset: nothing stored
      chk("rst_hold_count", {29'd0, count}, 32'd0);
      in_valid = 1'b0;
      rst = 1'b0;
      step();
      chk("rel_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rel_out_valid", {31'd0, out_valid}, 32'd0);

      // wrap on DEPTH=3: stream 0..9, out_ready toggling 1,0,1,0...
      nxt = 0;
      for (int cyc = 0; cyc < 60 && got.size() < 10; cyc++) begin
         in_valid3  = (nxt < 10);
         in_data3   = nxt;
         out_ready3 = (cyc % 2 == 0);
         #1;
         if (out_valid3 && out_ready3) got.push_back(out_data3);
         if (in_valid3 && in_ready3) nxt++;
         step();
      end
      in_valid3 = 1'b0; out_ready3 = 1'b0;
      chk("wrap_count_out", got.size(), 32'd10);
      for (int i = 0; i < 10 && i < got.size(); i++)
         chk($sformatf("wrap_flit%0d", i), got[i], i);
      chk("wrap_end_count", {30'd0, count3}, 32'd0);

      // random run against a queue model (DEPTH=4); starts empty
      q.delete();
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (!in_valid || in_ready) in_data = $urandom;   // hold data until accepted
         in_valid  = ($urandom_range(0, 3) != 0) ? 1'b1 : (in_valid && !in_ready);
         out_ready = ($urandom_range(0, 2) != 0);
         push_m = in_valid && (q.size() < 4);
         pop_m  = out_ready && (q.size() > 0);
         step();
         if (pop_m)  void'(q.pop_front());
         if (push_m) q.push_back(in_data);
         checks++;
         if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 4) ||
             count !== 3'(q.size()) || count > 3'd4 ||
             (q.size() != 0 && out_data !== q[0])) begin
            errors++;
            if (errors < 20)
               $display("FAIL rand cyc %0d: ov=%0b ir=%0b cnt=%0d data=%0h expected ov=%0b ir=%0b cnt=%0d data=%0h",
                        cyc, out_valid, in_ready, count, out_data,
                        q.size() != 0, q.size() < 4, q.size(),
                        (q.size() != 0) ? q[0] : 32'h0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
